banco_de_registradores_multiporta: RTL and testbench
====================================================

BANCO_DE_REGISTRADORES_MULTIPORTA -- requirements
Module: banco_de_registradores_multiporta

Interface
REQ-001 Parameter DATA_W, default 32, is the register width in bits.
REQ-002 Parameter ADDR_W, default 5, is the address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 Port: clock, input, 1, rising-edge clock.
REQ-006 Port: reset, input, 1, synchronous, active-high reset.
REQ-007 Port: we0, input, 1, write enable, write port 0.
REQ-008 Port: wa0, input, ADDR_W, write address, port 0.
REQ-009 Port: wd0, input, DATA_W, write data, port 0.
REQ-010 Port: we1, input, 1, write enable, write port 1.
REQ-011 Port: wa1, input, ADDR_W, write address, port 1.
REQ-012 Port: wd1, input, DATA_W, write data, port 1.
REQ-013 Ports: ra0 and ra1, input, ADDR_W each, read addresses.
REQ-014 Ports: rd0 and rd1, output, DATA_W each, combinational read data for ra0 and ra1.
REQ-015 Port: clear_req, input, 1, request a sequential sweep that zeroes all registers.
REQ-016 Port: clear_busy, output, 1, high while a sweep is in progress.
REQ-017 Port: clear_done, output, 1, one-cycle pulse when a sweep completes.

Function
REQ-018 Writes commit on the rising clock edge when weN=1, reset=0 and clear_busy=0.
REQ-019 If we0 and we1 are both set and wa0==wa1, port 1 data shall be stored and port 0 data discarded.
REQ-020 With ZERO_REG=1:
- writes to address 0 shall be ignored;
- any read of address 0 shall return 0, regardless of BYPASS.
REQ-021 With BYPASS=1, a read port whose address matches an enabled, committing write in the same cycle shall return that write data.
- If both write ports match, port 1 data is returned.
- ZERO_REG rules take precedence.
REQ-022 With BYPASS=0, read ports shall return the stored contents only; a same-cycle write is visible from the next cycle.
REQ-023 Writes dropped because clear_busy=1 shall not be forwarded.
REQ-024 The sweep FSM has three states: IDLE, SWEEP and DONE.
REQ-025 IDLE: clear_req=1 moves the FSM to SWEEP and loads index counter idx=0.
REQ-026 SWEEP: each cycle, regs[idx] is set to 0 and idx is incremented.
- The cycle that clears idx==DEPTH-1 moves the FSM to DONE.
- A sweep therefore lasts exactly DEPTH cycles.
REQ-027 DONE: clear_done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-028 clear_busy shall be 1 exactly in SWEEP and 0 in IDLE and DONE.
REQ-029 clear_req asserted in SWEEP or DONE shall be ignored; it is not queued.
REQ-030 Port writes in SWEEP shall be dropped entirely, including writes to registers already cleared.
REQ-031 Port writes in DONE shall commit normally.
REQ-032 Reads during SWEEP shall return current stored contents: 0 for cleared indices, old values for the rest.
REQ-033 idx width is ADDR_W+1 so the final compare does not wrap.

Reset
REQ-034 On a rising edge with reset=1, all DEPTH registers shall become 0.
REQ-035 On that same edge, the FSM shall go to IDLE, idx to 0, clear_busy to 0 and clear_done to 0.
REQ-036 Reset overrides both port writes and sweep activity in the same cycle, including a reset arriving mid-sweep.
REQ-037 After reset, rd0 and rd1 shall read 0 for every address.

Verification
REQ-038 Reset, then write 0xDEADBEEF to r5 via port 0; next cycle ra0=5 -> rd0=0xDEADBEEF.
REQ-039 Dual write in the same cycle: port 0 writes r7=0x11111111 and port 1 writes r7=0x22222222; next cycle ra1=7 -> rd1=0x22222222.
REQ-040 Hardwired zero: write 0x12345678 to r0 via both ports; with ra0=0 in the same cycle and the next cycle, rd0=0 in both cycles.
REQ-041 Bypass: BYPASS=1, we0=1, wa0=9, wd0=0xA5A5A5A5, ra0=9 -> rd0=0xA5A5A5A5 in the same cycle; with BYPASS=0, rd0 equals the old r9 value that cycle.
REQ-042 Sweep (DEPTH=32, all registers preloaded with 0xFFFFFFFF):
- Pulse clear_req; clear_busy is high for 32 cycles.
- A write of 0x55 to r3 during cycle 10 of the sweep is dropped.
- clear_done pulses once, then all reads return 0.
REQ-043 Reset mid-sweep: assert reset at sweep cycle 12 -> the next cycle shows clear_busy=0, clear_done=0, all registers 0; clear_done never pulses for the aborted sweep.

Source files
------------

// File: rtl/banco_de_registradores_multiporta.sv
// -----------------------------------------------------------------------------
// banco_de_registradores_multiporta
//
// Multi-ported register file: two write ports, two combinational read ports,
// optional hardwired-zero register 0, optional same-cycle write forwarding and
// a sequential clear engine that zeroes one register per cycle.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//   BYPASS   1: a committing write is visible on a matching read port in the
//               same cycle (port 1 has priority over port 0)
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset (clears every register)
//   we0/wa0/wd0 write port 0 enable / address / data
//   we1/wa1/wd1 write port 1 enable / address / data (wins on address clash)
//   ra0/ra1     read addresses
//   rd0/rd1     combinational read data
//   clear_req   start a sweep that zeroes all registers (only honoured in IDLE)
//   clear_busy  high while the sweep is running; port writes are dropped then
//   clear_done  one-cycle pulse after the last register has been cleared
// -----------------------------------------------------------------------------
module banco_de_registradores_multiporta #(
    parameter int unsigned DATA_W   = 32'd32,
    parameter int unsigned ADDR_W   = 32'd5,
    parameter int unsigned ZERO_REG = 32'd1,
    parameter int unsigned BYPASS   = 32'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam logic ZERO_EN   = (ZERO_REG != 32'd0);
    localparam logic BYPASS_EN = (BYPASS != 32'd0);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    // idx carries one extra bit so the last-index compare never wraps.
    localparam logic [ADDR_W:0]   IDX_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   IDX_LAST  = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    sweep_state_t      state_r, state_s;
    logic [ADDR_W:0]   idx_r, idx_s;
    logic              clear_busy_r, clear_done_r;
    logic              busy_s, done_s;

    logic [DATA_W-1:0] regs_r [DEPTH];

    logic              wr0_commit_s, wr1_commit_s;
    logic [DATA_W-1:0] rd0_s, rd1_s;

    // Read mux for one port: zero register first, then forwarded write
    // data (port 1 before port 0), otherwise the stored value.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              c0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              c1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] value;
        if (ZERO_EN && (ra == ADDR_ZERO)) begin
            value = DATA_ZERO;
        end else if (BYPASS_EN && c1 && (a1 == ra)) begin
            value = d1;
        end else if (BYPASS_EN && c0 && (a0 == ra)) begin
            value = d0;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // A write commits only outside reset and sweep, and never into a
    // hardwired-zero register; only committing writes are forwarded.
    assign wr0_commit_s = we0 & ~reset & ~clear_busy_r & ~(ZERO_EN & (wa0 == ADDR_ZERO));
    assign wr1_commit_s = we1 & ~reset & ~clear_busy_r & ~(ZERO_EN & (wa1 == ADDR_ZERO));

    // Combinational read data for both read ports.
    always_comb begin
        rd0_s = read_mux(ra0, regs_r[ra0], wr0_commit_s, wa0, wd0, wr1_commit_s, wa1, wd1);
        rd1_s = read_mux(ra1, regs_r[ra1], wr0_commit_s, wa0, wd0, wr1_commit_s, wa1, wd1);
    end

    assign rd0        = rd0_s;
    assign rd1        = rd1_s;
    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;

    // Sweep FSM next-state, index and registered-output decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_s = ST_SWEEP;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                idx_s = idx_r + IDX_ONE;
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_DONE: begin
                // A request here is dropped, not queued.
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
            end
        endcase
        busy_s = (state_s == ST_SWEEP);
        done_s = (state_s == ST_DONE);
    end

    // Sweep FSM state, index and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            clear_busy_r <= busy_s;
            clear_done_r <= done_s;
        end
    end

    // Register storage: reset and sweep clear dominate; port 1 beats port 0.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (reset) begin
                regs_r[i] <= DATA_ZERO;
            end else if ((state_r == ST_SWEEP) && (idx_r[ADDR_W-1:0] == ADDR_W'(i))) begin
                regs_r[i] <= DATA_ZERO;
            end else if (wr1_commit_s && (wa1 == ADDR_W'(i))) begin
                regs_r[i] <= wd1;
            end else if (wr0_commit_s && (wa0 == ADDR_W'(i))) begin
                regs_r[i] <= wd0;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

endmodule

// File: tb/tb_banco_de_registradores_multiporta.sv
// -----------------------------------------------------------------------------
// Bench for banco_de_registradores_multiporta. Two instances share all inputs:
// dut_a with forwarding enabled, dut_b without. A reference model (array of
// register contents plus sweep bookkeeping) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_banco_de_registradores_multiporta;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset, we0, we1, clear_req;
    logic [AW-1:0] wa0, wa1, ra0, ra1;
    logic [DW-1:0] wd0, wd1;
    logic [DW-1:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic          busy_a, done_a, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            busy_m, done_m;
    int            idx_m;

    always #5 clock = ~clock;

    banco_de_registradores_multiporta #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_a), .rd1(rd1_a),
        .clear_req(clear_req), .clear_busy(busy_a), .clear_done(done_a)
    );

    banco_de_registradores_multiporta #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_b), .rd1(rd1_b),
        .clear_req(clear_req), .clear_busy(busy_b), .clear_done(done_b)
    );

    function automatic bit commits(input logic we, input logic [AW-1:0] wa);
        return (we === 1'b1) && (reset === 1'b0) && !busy_m && (wa != 0);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && commits(we1, wa1) && wa1 == a) return wd1;
        if (byp && commits(we0, wa0) && wa0 == a) return wd0;
        return mem_m[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; we0 = 0; we1 = 0; clear_req = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    endtask

    // wait to mid-cycle, then compare every output with the model
    task automatic settle_compare(input string tag);
        #3;
        check({tag, ".a.rd0"}, rd0_a, model_read(ra0, 1'b1));
        check({tag, ".a.rd1"}, rd1_a, model_read(ra1, 1'b1));
        check({tag, ".b.rd0"}, rd0_b, model_read(ra0, 1'b0));
        check({tag, ".b.rd1"}, rd1_b, model_read(ra1, 1'b0));
        check({tag, ".a.busy"}, 32'(busy_a), 32'(busy_m));
        check({tag, ".a.done"}, 32'(done_a), 32'(done_m));
        check({tag, ".b.busy"}, 32'(busy_b), 32'(busy_m));
        check({tag, ".b.done"}, 32'(done_b), 32'(done_m));
    endtask

    // clock edge; the model applies the same edge, then step off the edge
    task automatic advance();
        bit c0, c1;
        @(posedge clock);
        c0 = commits(we0, wa0);
        c1 = commits(we1, wa1);
        if (reset) begin
            foreach (mem_m[i]) mem_m[i] = 0;
            busy_m = 0; done_m = 0; idx_m = 0;
        end else if (busy_m) begin
            mem_m[idx_m] = 0;
            idx_m++;
            if (idx_m == DEPTH) begin
                busy_m = 0;
                done_m = 1;
            end
        end else begin
            if (c0) mem_m[wa0] = wd0;
            if (c1) mem_m[wa1] = wd1;
            if (done_m) done_m = 0;
            else if (clear_req) begin
                busy_m = 1;
                idx_m  = 0;
            end
        end
        #1;
    endtask

    task automatic scan_zero(input string tag);
        for (int i = 0; i < DEPTH / 2; i++) begin
            ra0 = AW'(i);
            ra1 = AW'(i + DEPTH / 2);
            settle_compare(tag);
            check({tag, ".zero0"}, rd0_a, 32'h0);
            check({tag, ".zero1"}, rd1_a, 32'h0);
            advance();
        end
    endtask

    task automatic preload(input bit rand_data);
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle_inputs();
            we0 = 1; wa0 = AW'(2 * i);
            we1 = 1; wa1 = AW'(2 * i + 1);
            wd0 = rand_data ? $urandom : 32'hFFFF_FFFF;
            wd1 = rand_data ? $urandom : 32'hFFFF_FFFF;
            settle_compare("preload");
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        int busy_cnt, done_cnt;
        foreach (mem_m[i]) mem_m[i] = 0;
        busy_m = 0; done_m = 0; idx_m = 0;
        idle_inputs();
        ra0 = 0; ra1 = 0;

        // reset: contents are unknown before, so only compare afterwards
        reset = 1;
        advance();
        advance();
        reset = 0;
        scan_zero("after_reset");

        // single write then read back
        idle_inputs();
        we0 = 1; wa0 = 5; wd0 = 32'hDEAD_BEEF; ra0 = 5;
        settle_compare("wr_r5");
        advance();
        idle_inputs();
        settle_compare("rd_r5");
        check("r5.a", rd0_a, 32'hDEAD_BEEF);
        check("r5.b", rd0_b, 32'hDEAD_BEEF);
        advance();

        // address clash: port 1 wins
        we0 = 1; wa0 = 7; wd0 = 32'h1111_1111;
        we1 = 1; wa1 = 7; wd1 = 32'h2222_2222; ra1 = 7;
        settle_compare("dual_wr");
        check("dual_fwd.a", rd1_a, 32'h2222_2222);
        advance();
        idle_inputs();
        settle_compare("dual_rd");
        check("dual.a", rd1_a, 32'h2222_2222);
        check("dual.b", rd1_b, 32'h2222_2222);
        advance();

        // hardwired zero register
        we0 = 1; wa0 = 0; wd0 = 32'h1234_5678;
        we1 = 1; wa1 = 0; wd1 = 32'h1234_5678; ra0 = 0;
        settle_compare("r0_wr");
        check("r0_same.a", rd0_a, 32'h0);
        check("r0_same.b", rd0_b, 32'h0);
        advance();
        idle_inputs();
        settle_compare("r0_rd");
        check("r0_next.a", rd0_a, 32'h0);
        check("r0_next.b", rd0_b, 32'h0);
        advance();

        // forwarding vs. no forwarding
        we0 = 1; wa0 = 9; wd0 = 32'h1357_9BDF;
        settle_compare("r9_old");
        advance();
        we0 = 1; wa0 = 9; wd0 = 32'hA5A5_A5A5; ra0 = 9;
        settle_compare("r9_byp");
        check("bypass.a", rd0_a, 32'hA5A5_A5A5);
        check("nobypass.b", rd0_b, 32'h1357_9BDF);
        advance();
        idle_inputs();
        settle_compare("r9_new");
        check("r9_next.b", rd0_b, 32'hA5A5_A5A5);
        advance();

        // randomized traffic with occasional reset and sweep requests
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            clear_req = ($urandom_range(0, 29) == 0);
            we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, 31)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, 31)); wd1 = $urandom;
            ra0 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, 31));
            settle_compare("random");
            advance();
        end

        // full sweep over registers preloaded with all ones
        idle_inputs();
        reset = 1;
        advance();
        reset = 0;
        preload(1'b0);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            idle_inputs();
            if (k == 0 || k == 15) clear_req = 1;
            if (k == 10) begin
                we0 = 1; wa0 = 3; wd0 = 32'h55;
            end
            ra0 = 3;
            ra1 = AW'($urandom_range(0, 31));
            settle_compare("sweep");
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            advance();
        end
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        scan_zero("after_sweep");

        // reset in the middle of a sweep aborts it
        preload(1'b1);
        done_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            idle_inputs();
            if (k == 0) clear_req = 1;
            if (k == 12) reset = 1;
            ra0 = AW'($urandom_range(0, 31));
            ra1 = AW'($urandom_range(0, 31));
            settle_compare("abort");
            if (k == 13) begin
                check("abort.busy", 32'(busy_a), 32'd0);
                check("abort.done", 32'(done_a), 32'd0);
            end
            if (k >= 13 && done_a) done_cnt++;
            advance();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        scan_zero("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
